relu_maxpool2: RTL and testbench

Streaming ReLU and 2×2 stride-2 max-pool stage that sits directly downstream of the `conv1`/`conv2`/`conv3` 3×3 convolution blocks. It consumes their 32-bit signed raster output of 26×26 valid pixels per frame, one pixel per clock when `in_valid` is high. It emits a 13×13 pooled raster on a valid-qualified output. It holds one half-row of partial maxima between even and odd rows, so it needs no full-frame storage.

---
 rtl/cnn_pkg.sv | 19 +
 rtl/pool_linebuf.sv | 32 +++
 rtl/relu_maxpool2.sv | 107 ++++++++++
 tb/tb_relu_maxpool2.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks.
//   DATA_W     : width of the signed conv/pool samples
//   CONV_COLS  : conv output pixels per row
//   CONV_ROWS  : conv output rows per frame
//   POOL_COLS  : pooled pixels per row after 2x2 stride-2 max-pool
//   smax()     : signed maximum of two samples (ties return that value)
package cnn_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CONV_COLS = 26;
  localparam int unsigned CONV_ROWS = 26;
  localparam int unsigned POOL_COLS = CONV_COLS / 2;

  function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_linebuf.sv
// Half-row buffer of horizontal partial maxima, written on even rows and read on odd rows.
// No reset: every entry is written before it is read.
//   clk   : clock, rising edge
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index (asynchronous read)
//   rdata : read data
module pool_linebuf #(
  parameter int unsigned DEPTH  = 13,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic [AW-1:0]            raddr,
  output logic signed [DATA_W-1:0] rdata
);

  logic signed [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/relu_maxpool2.sv
// Streaming ReLU + 2x2 stride-2 max-pool for the conv output raster.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : data_in carries a pixel this cycle
//   data_in    : signed conv pixel
//   out_valid  : one-cycle pulse, data_out is a pooled pixel
//   data_out   : signed pooled pixel, held while out_valid is low
//   frame_done : pulses with the last pooled pixel of a frame
module relu_maxpool2
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W  = cnn_pkg::DATA_W,
  parameter int unsigned COLS    = cnn_pkg::CONV_COLS,
  parameter int unsigned ROWS    = cnn_pkg::CONV_ROWS,
  parameter bit          RELU_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] data_in,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     frame_done
);

  localparam int unsigned HALF = COLS / 2;
  localparam int unsigned CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned AW   = (HALF > 1) ? $clog2(HALF) : 1;

  if ((COLS % 2) != 0 || (ROWS % 2) != 0) begin : g_dim_check
    $error("relu_maxpool2: COLS and ROWS must both be even");
  end

  logic [CW-1:0]            col_q;
  logic [RW-1:0]            row_q;
  logic signed [DATA_W-1:0] hold_q;
  logic signed [DATA_W-1:0] x;
  logic signed [DATA_W-1:0] pair_max;
  logic signed [DATA_W-1:0] pool_max;
  logic signed [DATA_W-1:0] lb_rdata;
  logic [AW-1:0]            lb_addr;
  logic                     col_last;
  logic                     row_last;
  logic                     lb_we;

  assign col_last = (col_q == CW'(COLS - 1));
  assign row_last = (row_q == RW'(ROWS - 1));
  assign lb_addr  = AW'(col_q >> 1);

  always_comb begin
    x = data_in;
    if (RELU_EN && data_in[DATA_W-1]) begin
      x = '0;
    end
  end

  assign pair_max = smax(hold_q, x);
  assign pool_max = smax(lb_rdata, pair_max);

  // Even rows park the horizontal pair max; odd rows consume it.
  assign lb_we = in_valid && col_q[0] && !row_q[0];

  pool_linebuf #(
    .DEPTH  (HALF),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_linebuf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (pair_max),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      hold_q     <= '0;
      out_valid  <= 1'b0;
      data_out   <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
        if (!col_q[0]) begin
          hold_q <= x;
        end
        if (row_q[0] && col_q[0]) begin
          out_valid  <= 1'b1;
          data_out   <= pool_max;
          frame_done <= row_last && col_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_relu_maxpool2.sv
module tb_relu_maxpool2;

  localparam int R = 26;
  localparam int C = 26;
  localparam int PR = R / 2;
  localparam int PC = C / 2;

  typedef struct {
    logic signed [31:0] data;
    logic               last;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [31:0] data_in = '0;
  logic               ov1, fd1, ov0, fd0;
  logic signed [31:0] do1, do0;

  int checks = 0;
  int errors = 0;
  int ov_cnt = 0;
  int fd_cnt = 0;

  exp_t q1[$];
  exp_t q0[$];
  logic signed [31:0] fb [R][C];

  always #5 clk = ~clk;

  relu_maxpool2 #(.RELU_EN(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .data_in    (data_in),
    .out_valid  (ov1),
    .data_out   (do1),
    .frame_done (fd1)
  );

  relu_maxpool2 #(.RELU_EN(1'b0)) dut_raw (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .data_in    (data_in),
    .out_valid  (ov0),
    .data_out   (do0),
    .frame_done (fd0)
  );

  // ---------------- reference model ----------------
  function automatic logic signed [31:0] xmap(input logic signed [31:0] v, input bit relu);
    return (relu && v < 0) ? 32'sd0 : v;
  endfunction

  function automatic logic signed [31:0] pool_ref(input int i, input int j, input bit relu);
    logic signed [31:0] m;
    m = xmap(fb[2*i][2*j], relu);
    for (int dr = 0; dr < 2; dr++) begin
      for (int dc = 0; dc < 2; dc++) begin
        if (xmap(fb[2*i+dr][2*j+dc], relu) > m) m = xmap(fb[2*i+dr][2*j+dc], relu);
      end
    end
    return m;
  endfunction

  // kind: 0 ramp, 1 all -5, 2 rotating max sweep, 3 random
  task automatic fill_frame(input int kind);
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        case (kind)
          0: fb[r][c] = 100 * r + c;
          1: fb[r][c] = -5;
          2: begin
            int pos;
            pos = ((r / 2) * PC + (c / 2)) % 4;
            fb[r][c] = (pos == (r % 2) * 2 + (c % 2)) ? 32'sd7 : -32'sd2000000000;
          end
          default: fb[r][c] = $urandom;
        endcase
      end
    end
  endtask

  // Expect every pooled pixel whose bottom-right input lies within the first n_px pixels.
  task automatic push_expect(input int n_px);
    exp_t e;
    for (int i = 0; i < PR; i++) begin
      for (int j = 0; j < PC; j++) begin
        if ((2 * i + 1) * C + 2 * j + 1 < n_px) begin
          e.last = (i == PR - 1) && (j == PC - 1);
          e.data = pool_ref(i, j, 1'b1);
          q1.push_back(e);
          e.data = pool_ref(i, j, 1'b0);
          q0.push_back(e);
        end
      end
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    exp_t e;
    if (ov1) begin
      ov_cnt++;
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL relu_out: unexpected out_valid, data=%0d", do1);
      end else begin
        e = q1.pop_front();
        if (do1 !== e.data || fd1 !== e.last) begin
          errors++;
          $display("FAIL relu_out: got data=%0d fd=%b, want data=%0d fd=%b",
                   do1, fd1, e.data, e.last);
        end
      end
    end else if (fd1) begin
      checks++;
      errors++;
      $display("FAIL relu_fd: frame_done=1 without out_valid, want 0");
    end
    if (fd1) fd_cnt++;
    if (ov0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL raw_out: unexpected out_valid, data=%0d", do0);
      end else begin
        e = q0.pop_front();
        if (do0 !== e.data || fd0 !== e.last) begin
          errors++;
          $display("FAIL raw_out: got data=%0d fd=%b, want data=%0d fd=%b",
                   do0, fd0, e.data, e.last);
        end
      end
    end else if (fd0) begin
      checks++;
      errors++;
      $display("FAIL raw_fd: frame_done=1 without out_valid, want 0");
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_px(input logic signed [31:0] v);
    in_valid = 1'b1;
    data_in  = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_frame(input int n_px, input bit gaps);
    for (int p = 0; p < n_px; p++) begin
      if (gaps && $urandom_range(5) == 0) idle(1);
      send_px(fb[p / C][p % C]);
      if (gaps && (p % C) == C - 1) idle(2);
    end
  endtask

  task automatic check_val(input string name, input logic signed [31:0] got,
                           input logic signed [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (q1.size() != 0 || q0.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d/%0d expected outputs never appeared, want 0",
               name, q1.size(), q0.size());
    end
  endtask

  task automatic run_frame(input int kind, input bit gaps, input string name);
    fill_frame(kind);
    push_expect(R * C);
    drive_frame(R * C, gaps);
    idle(3);
    check_drained(name);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int ov_base;
    int fd_base;
    #2;
    check_val("reset_out_valid", 32'(ov1), 0);
    check_val("reset_data_out", do1, 0);
    check_val("reset_frame_done", 32'(fd1), 0);
    check_val("reset_raw_data_out", do0, 0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Ramp frame, continuous
    fill_frame(0);
    check_val("model_ramp_first", pool_ref(0, 0, 1'b1), 101);
    check_val("model_ramp_last", pool_ref(PR - 1, PC - 1, 1'b1), 2525);
    fd_base = fd_cnt;
    ov_base = ov_cnt;
    run_frame(0, 1'b0, "ramp");
    check_val("ramp_out_count", ov_cnt - ov_base, PR * PC);
    check_val("ramp_frame_done", fd_cnt - fd_base, 1);

    // Negative clamp / signed compare
    fill_frame(1);
    check_val("model_neg_relu", pool_ref(3, 4, 1'b1), 0);
    check_val("model_neg_raw", pool_ref(3, 4, 1'b0), -5);
    run_frame(1, 1'b0, "neg5");

    // Max position sweep
    fill_frame(2);
    check_val("model_sweep", pool_ref(5, 7, 1'b1), 7);
    run_frame(2, 1'b0, "sweep");

    // Random data with conv-style gaps and stalls
    run_frame(3, 1'b1, "random_gaps");
    run_frame(3, 1'b0, "random");

    // Ramp with gaps: output count must still be a full frame
    ov_base = ov_cnt;
    run_frame(0, 1'b1, "ramp_gaps");
    check_val("gap_out_count", ov_cnt - ov_base, PR * PC);

    // Reset mid-frame at row 13, col 10
    fill_frame(3);
    push_expect(13 * C + 11);
    drive_frame(13 * C + 11, 1'b0);
    idle(2);
    check_drained("partial");
    rst_n = 1'b0;
    #1;
    check_val("midreset_out_valid", 32'(ov1), 0);
    check_val("midreset_raw_out_valid", 32'(ov0), 0);
    idle(1);
    rst_n = 1'b1;
    ov_base = ov_cnt;
    run_frame(0, 1'b0, "post_reset_ramp");
    check_val("post_reset_count", ov_cnt - ov_base, PR * PC);

    // Back-to-back ramp frames, no idle between
    fill_frame(0);
    fd_base = fd_cnt;
    push_expect(R * C);
    push_expect(R * C);
    drive_frame(R * C, 1'b0);
    drive_frame(R * C, 1'b0);
    idle(3);
    check_drained("back_to_back");
    check_val("b2b_frame_done", fd_cnt - fd_base, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
